handshake_fifo: RTL
===================

Name: handshake_fifo

Overview:
- Elastic buffer stage placed directly upstream of an arf input port (between a producer and `din_*`) or downstream of an arf output port (between `dout_*` and a consumer).
- Upstream side acts as a requester: it drives req and receives an ack pulse with data.
- Downstream side acts as a responder, mirroring the producer's behaviour: it receives req and returns an ack pulse with data.
- Decouples producer/consumer stalls from the dataflow graph and provides occupancy and overflow visibility to the bench.

Parameters:
data_width, 32, payload width in bits
depth, 8, number of storage entries; power of two, >= 2
addr_width, 3, log2(depth); must match depth

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
req_l  output  1  fetch request to upstream; registered
ack_l  input  1  upstream acknowledge; one-cycle pulse, din valid in the same cycle
din  input  data_width  upstream payload, sampled when ack_l=1
req_r  input  1  downstream request
ack_r  output  1  downstream acknowledge; one-cycle pulse; registered
dout  output  data_width  downstream payload, valid while ack_r=1; holds last value otherwise
count  output  addr_width+1  current occupancy, 0..depth
overflow  output  1  sticky error flag: ack_l arrived while full

Behaviour:
- Reset (rst=1 at a clock edge):
  - req_l=0, ack_r=0, dout=0, count=0, overflow=0.
  - Read and write pointers cleared.
  - Memory contents are don't-care.
  - Reset mid-transfer discards all stored data and any in-flight ack.
- Storage: circular buffer, pointers addr_width bits wide, wrap from depth-1 to 0.
- Push:
  - On a cycle with ack_l=1 and count<depth: mem[wptr]<=din, wptr+1.
  - On ack_l=1 with count==depth: data is dropped, overflow<=1, and overflow stays 1 until reset.
- Upstream request policy, registered:
  - req_l<=1 when the next-cycle occupancy is < depth-1. One slot is always reserved for an ack already in flight.
  - Otherwise req_l<=0.
  - req_l is forced to 0 in the cycle ack_l is seen. This gives the producer's req & ~ack pattern, at most one ack every two cycles.
- Pop (responder):
  - If req_r=1, ack_r=0 and count>0 (pre-update count): ack_r<=1, dout<=mem[rptr], rptr+1.
  - Otherwise ack_r<=0.
  - So ack_r is never high two consecutive cycles. Back-to-back pops take at least 2 cycles each.
- Latency:
  - A word written at edge N is poppable at edge N+1 at the earliest.
  - Empty to first ack_r is 1 cycle after the push edge.
- Simultaneous push and pop in one cycle:
  - count is unchanged.
  - The pop returns the old head, never the incoming word, unless count was 0. If count was 0, no pop occurs that cycle.
- count updates: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full (count==depth): no pop is blocked; a push drops data and sets overflow.
- Empty (count==0): req_r is ignored and ack_r stays 0.
- Ordering: strict FIFO; no reordering and no duplication.
- Width rule: payload is stored verbatim; no arithmetic on data.

Test Plan:
- Reset then idle, req_r=0 -> req_l=1 from cycle 1; accepting producer acks 0,1,2,... fills to count=7 with depth=8 and stops requesting. req_l=0 while count>=7; overflow=0.
- Fill 7 words (0..6), then req_r held 1 -> ack_r pulses every other cycle with dout 0,1,2,...,6 in order. count returns to 0; ack_r stays 0 afterwards.
- Producer fail_rate=0 and consumer req held constantly over 5000 words -> consumer receives 0..4999 in order. No overflow; count never exceeds 7.
- Wrap-around: push 20 words with interleaved pops keeping count between 1 and 4 -> pointers wrap twice; output sequence matches input exactly.
- Forced ack_l pulse with din=0xDEAD while count=8 -> word not stored, overflow=1 and held. Subsequent pops still return the previous 8 words unchanged.
- Assert rst for one cycle while count=5 and ack_r=1 -> next cycle ack_r=0, count=0, overflow=0. The following pop request gets no ack until a new push.

Source files
------------

// File: rtl/handshake_fifo.sv
// ---------------------------------------------------------------------------
// handshake_fifo
//   Elastic buffer between a producer and a consumer that both use a
//   req/ack-pulse handshake. On the upstream side this block is the
//   requester: it raises req_l and takes in one word per ack_l pulse. On the
//   downstream side it is the responder: it answers req_r with a one-cycle
//   ack_r pulse carrying the head word on dout.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   req_l     fetch request to upstream (registered)
//   ack_l     upstream acknowledge pulse; din is valid in the same cycle
//   din       upstream payload
//   req_r     downstream request
//   ack_r     downstream acknowledge pulse (registered)
//   dout      downstream payload, valid while ack_r=1, holds otherwise
//   count     current occupancy, 0..depth
//   overflow  sticky flag: ack_l arrived while the buffer was full
// ---------------------------------------------------------------------------
module handshake_fifo #(
  parameter int data_width = 32,
  parameter int depth      = 8,
  parameter int addr_width = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req_l,
  input  logic                  ack_l,
  input  logic [data_width-1:0] din,
  input  logic                  req_r,
  output logic                  ack_r,
  output logic [data_width-1:0] dout,
  output logic [addr_width:0]   count,
  output logic                  overflow
);

  localparam logic [addr_width:0]   CNT_ZERO_C  = {(addr_width+1){1'b0}};
  localparam logic [addr_width:0]   CNT_ONE_C   = (addr_width+1)'(1);
  localparam logic [addr_width:0]   CNT_FULL_C  = (addr_width+1)'(depth);
  // One slot stays free for an ack that may already be in flight.
  localparam logic [addr_width:0]   CNT_REQ_C   = (addr_width+1)'(depth - 1);
  localparam logic [addr_width-1:0] PTR_ZERO_C  = {addr_width{1'b0}};
  localparam logic [addr_width-1:0] PTR_ONE_C   = (addr_width)'(1);
  localparam logic [data_width-1:0] DATA_ZERO_C = {data_width{1'b0}};

  logic [data_width-1:0] mem_r [depth];
  logic [addr_width-1:0] wptr_r;
  logic [addr_width-1:0] rptr_r;
  logic [addr_width:0]   count_r;
  logic                  req_l_r;
  logic                  ack_r_r;
  logic [data_width-1:0] dout_r;
  logic                  overflow_r;

  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic [addr_width:0]   count_nxt_s;
  logic                  req_l_nxt_s;

  // Handshake decode, next occupancy and next upstream request.
  always_comb begin
    full_s      = (count_r == CNT_FULL_C);
    empty_s     = (count_r == CNT_ZERO_C);
    push_s      = ack_l & ~full_s;
    // ack_r_r gates the pop so acks are never back to back; the pre-update
    // count means a word arriving this cycle is never popped this cycle.
    pop_s       = req_r & ~ack_r_r & ~empty_s;
    count_nxt_s = count_r;
    req_l_nxt_s = 1'b0;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_ONE_C;
    end else if (!push_s && pop_s) begin
      count_nxt_s = count_r - CNT_ONE_C;
    end else begin
      count_nxt_s = count_r;
    end
    // Drop the request in the ack cycle so the producer sees req & ~ack.
    if (ack_l) begin
      req_l_nxt_s = 1'b0;
    end else begin
      req_l_nxt_s = (count_nxt_s < CNT_REQ_C);
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wptr_r] <= din;
    end
  end

  // Pointers, occupancy, handshake outputs and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r     <= PTR_ZERO_C;
      rptr_r     <= PTR_ZERO_C;
      count_r    <= CNT_ZERO_C;
      req_l_r    <= 1'b0;
      ack_r_r    <= 1'b0;
      dout_r     <= DATA_ZERO_C;
      overflow_r <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      req_l_r <= req_l_nxt_s;
      ack_r_r <= pop_s;
      if (push_s) begin
        wptr_r <= wptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        dout_r <= mem_r[rptr_r];
        rptr_r <= rptr_r + PTR_ONE_C;
      end
      if (ack_l && full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign req_l    = req_l_r;
  assign ack_r    = ack_r_r;
  assign dout     = dout_r;
  assign count    = count_r;
  assign overflow = overflow_r;

endmodule
